// File: rtl/sum3_pkg.sv
// Shared widths and types for the sum3_pipe operand-sum pipeline.
package sum3_pkg;

    localparam int OP_W  = 5;
    localparam int SUM_W = 7;
    localparam int CNT_W = 8;

    typedef logic [OP_W-1:0]  op_t;
    typedef logic [SUM_W-1:0] sum_t;

    // Largest possible result; SUM_W must be wide enough to hold it.
    localparam int SUM_MAX = 3 * ((1 << OP_W) - 1);

endpackage

// File: rtl/sum3_pipe_reg.sv
// Generic valid/data pipeline register: the valid bit takes its next value every
// cycle, while the data only moves on load and otherwise holds.
module sum3_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_d_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d_i;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sum3_pipe.sv
// Two-stage b+c+d adder with valid/ready flow control and an output transaction counter.
// Define SUM3_PIPE_PARITY_EN to add the registered out_par (XOR-reduce of out_sum).
module sum3_pipe
    import sum3_pkg::*;
#(
    parameter int OP_W  = sum3_pkg::OP_W,
    parameter int SUM_W = sum3_pkg::SUM_W,
    parameter int CNT_W = sum3_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_b,
    input  logic [OP_W-1:0]  in_c,
    input  logic [OP_W-1:0]  in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
`ifdef SUM3_PIPE_PARITY_EN
    output logic             out_par,
`endif
    output logic [CNT_W-1:0] txn_cnt
);

    localparam int P1_W = OP_W + 1;
    localparam int S1_W = P1_W + OP_W;
`ifdef SUM3_PIPE_PARITY_EN
    localparam int S2_W = SUM_W + 1;
`else
    localparam int S2_W = SUM_W;
`endif

    logic             s1_load, s2_load;
    logic             v1_d, v1_q, v2_d, v2_q;
    logic [S1_W-1:0]  s1_d, s1_q;
    logic [S2_W-1:0]  s2_d, s2_q;
    logic [P1_W-1:0]  p1_q;
    logic [OP_W-1:0]  r1_q;
    logic [SUM_W-1:0] sum_d;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // a producer holds valid and data until that edge, and ready may depend
    // combinationally on valid. in_ready follows out_ready through the same cycle so a
    // full pipe can drain and refill in one edge.
    always_comb begin
        s2_load  = v1_q && (!v2_q || out_ready);
        in_ready = !v1_q || s2_load;
        s1_load  = in_valid && in_ready;
        v1_d     = s1_load || (v1_q && !s2_load);
        v2_d     = s2_load || (v2_q && !out_ready);
    end

    assign s1_d         = {({1'b0, in_b} + {1'b0, in_c}), in_d};
    assign {p1_q, r1_q} = s1_q;
    assign sum_d        = SUM_W'(p1_q) + SUM_W'(r1_q);

`ifdef SUM3_PIPE_PARITY_EN
    assign s2_d    = {^sum_d, sum_d};
    assign out_par = s2_q[SUM_W];
`else
    assign s2_d    = sum_d;
`endif

    sum3_pipe_reg #(.W(S1_W)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_d_i (v1_d),
        .load_i    (s1_load),
        .data_i    (s1_d),
        .valid_o   (v1_q),
        .data_o    (s1_q)
    );

    sum3_pipe_reg #(.W(S2_W)) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_d_i (v2_d),
        .load_i    (s2_load),
        .data_i    (s2_d),
        .valid_o   (v2_q),
        .data_o    (s2_q)
    );

    assign out_valid = v2_q;
    assign out_sum   = s2_q[SUM_W-1:0];

    // Free-running wrap, no overflow flag.
    assign cnt_d = (v2_q && out_ready) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign txn_cnt = cnt_q;

endmodule
